// File: rtl/act_unit_pipe.sv
// Two-stage valid/ready activation stage over CH signed fixed-point lanes.
// Stage 1 captures the beat and its mode. Stage 2 holds the activated lanes and the zero mask.
module act_unit_pipe #(
  parameter int unsigned N          = 16,
  parameter int unsigned Q          = 12,
  parameter int unsigned CH         = 4,
  parameter int unsigned LEAK_SHIFT = 3,
  parameter int unsigned CLIP_VAL   = 6 << Q
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      mode,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CH*N-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH*N-1:0] out_data,
  output logic [CH-1:0]   out_zero_mask
);

  localparam int unsigned W = CH * N;
  localparam logic signed [N-1:0] CLIP_S = N'(CLIP_VAL);

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_RELU   = 2'd1,
    MODE_LEAKY  = 2'd2,
    MODE_CLIP   = 2'd3
  } act_mode_e;

  logic            v1_q, v1_d;
  logic            v2_q, v2_d;
  act_mode_e       mode1_q, mode1_d;
  logic [W-1:0]    data1_q, data1_d;
  logic [W-1:0]    data2_q, data2_d;
  logic [CH-1:0]   mask2_q, mask2_d;
  logic [W-1:0]    act_data;
  logic [CH-1:0]   act_mask;
  logic            in_fire, adv2, out_fire;

  // One lane of activation; the sign bit picks the negative-input branch.
  function automatic logic signed [N-1:0] act_lane(input logic signed [N-1:0] x,
                                                   input act_mode_e m);
    logic signed [N-1:0] y;
    y = x;
    case (m)
      MODE_RELU:  if (x[N-1]) y = '0;
      MODE_LEAKY: if (x[N-1]) y = x >>> LEAK_SHIFT;
      MODE_CLIP: begin
        if (x[N-1])          y = '0;
        else if (x > CLIP_S) y = CLIP_S;
      end
      default:    y = x;
    endcase
    return y;
  endfunction

  // Per-lane activation and zero detection on the stage-1 beat.
  always_comb begin
    act_data = '0;
    act_mask = '0;
    for (int k = 0; k < int'(CH); k++) begin
      act_data[k*N +: N] = act_lane(data1_q[k*N +: N], mode1_q);
      act_mask[k]        = (act_data[k*N +: N] == '0);
    end
  end

  // Handshake and next-state; ready stays high while reset is held.
  always_comb begin
    in_ready = reset || !v1_q || !v2_q || out_ready;
    in_fire  = in_valid && in_ready;
    adv2     = v1_q && (!v2_q || out_ready);
    out_fire = v2_q && out_ready;

    v1_d    = v1_q;
    v2_d    = v2_q;
    mode1_d = mode1_q;
    data1_d = data1_q;
    data2_d = data2_q;
    mask2_d = mask2_q;

    if (in_fire) begin
      v1_d    = 1'b1;
      mode1_d = act_mode_e'(mode);
      data1_d = in_data;
    end else if (adv2) begin
      v1_d = 1'b0;
    end

    if (adv2) begin
      v2_d    = 1'b1;
      data2_d = act_data;
      mask2_d = act_mask;
    end else if (out_fire) begin
      v2_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      mode1_q <= MODE_BYPASS;
      data1_q <= '0;
      data2_q <= '0;
      mask2_q <= '0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      mode1_q <= mode1_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
      mask2_q <= mask2_d;
    end
  end

  assign out_valid     = v2_q;
  assign out_data      = data2_q;
  assign out_zero_mask = mask2_q;

endmodule

// File: tb/tb_act_unit_pipe.sv
// Bench for act_unit_pipe: directed scenarios plus a randomized stream
// against an arithmetic reference model and an in-order scoreboard.
module tb_act_unit_pipe;

  localparam int unsigned N    = 16;
  localparam int unsigned Q    = 12;
  localparam int unsigned CH   = 4;
  localparam int unsigned LS   = 3;
  localparam int unsigned CLIP = 6 << Q;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    mode = 2'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [63:0]   out_data;
  logic [3:0]    out_zero_mask;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] d;
    logic [3:0]  m;
  } beat_t;

  beat_t sb[$];
  logic        held_v = 1'b0;
  logic [63:0] held_d = '0;
  logic [3:0]  held_m = '0;

  always #5 clk = ~clk;

  act_unit_pipe #(.N(N), .Q(Q), .CH(CH), .LEAK_SHIFT(LS), .CLIP_VAL(CLIP)) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero_mask(out_zero_mask)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference activation with plain integer arithmetic (floor division for leaky).
  function automatic int ref_lane(input int x, input int md);
    int d;
    d = 1 << LS;
    case (md)
      0: return x;
      1: return (x < 0) ? 0 : x;
      2: return (x < 0) ? -(((-x) + d - 1) / d) : x;
      default: return (x < 0) ? 0 : ((x > int'(CLIP)) ? int'(CLIP) : x);
    endcase
  endfunction

  function automatic beat_t ref_beat(input logic [63:0] d, input logic [1:0] m);
    beat_t b;
    logic signed [15:0] s;
    int x, y;
    b.d = '0;
    b.m = '0;
    for (int k = 0; k < 4; k++) begin
      s = d[k*16 +: 16];
      x = int'(s);
      y = ref_lane(x, int'(m));
      b.d[k*16 +: 16] = 16'(y);
      b.m[k] = (y == 0);
    end
    return b;
  endfunction

  function automatic logic [63:0] pack(input logic [15:0] a, input logic [15:0] b,
                                       input logic [15:0] c, input logic [15:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [15:0] rand_lane();
    case ($urandom_range(0, 7))
      0: return 16'h8000;
      1: return 16'hFFFF;
      2: return 16'h0000;
      3: return 16'(CLIP);
      4: return 16'(CLIP + 1);
      5: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_data", out_data, held_d);
        chk("stall_mask", 64'(out_zero_mask), 64'(held_m));
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
      held_m = out_zero_mask;
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          beat_t e;
          e = sb.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_mask", 64'(out_zero_mask), 64'(e.m));
        end
      end
      if (in_valid && in_ready) sb.push_back(ref_beat(in_data, mode));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int g;
    g = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && g < 50) begin
      tick();
      g++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic directed(input string tag, input logic [1:0] m, input logic [63:0] d,
                          input logic [63:0] ed, input logic [3:0] em);
    in_valid = 1'b1; mode = m; in_data = d; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_early_valid"}, 64'(out_valid), 64'd0);
    tick();
    @(negedge clk);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_data"}, out_data, ed);
    chk({tag, "_mask"}, 64'(out_zero_mask), 64'(em));
    tick();
  endtask

  task automatic rand_phase(input int nbeats);
    int  sent, guard;
    logic acc;
    sent = 0; guard = 0;
    in_valid = 1'b0;
    while (sent < nbeats && guard < 8000) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        mode     = 2'($urandom_range(0, 3));
        in_data  = pack(rand_lane(), rand_lane(), rand_lane(), rand_lane());
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) sent++;
      tick();
      if (acc) in_valid = 1'b0;
      guard++;
    end
    in_valid = 1'b0;
    chk("rand_sent", 64'(sent), 64'(nbeats));
  endtask

  initial begin
    int acc;

    // Reset state
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_mask", 64'(out_zero_mask), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    tick();

    // Test 1: ReLU stream, latency and throughput
    for (int i = 0; i < 8; i++) begin
      in_valid = (i < 4); mode = 2'd1;
      in_data  = pack(16'h1000, 16'hF000, 16'h0000, 16'h7FFF);
      @(negedge clk);
      chk("t1_valid", 64'(out_valid), 64'(i >= 2 && i <= 5));
      if (i == 2) begin
        chk("t1_data", out_data, pack(16'h1000, 16'h0000, 16'h0000, 16'h7FFF));
        chk("t1_mask", 64'(out_zero_mask), 64'(4'b0110));
      end
      tick();
    end
    in_valid = 1'b0;

    // Tests 2 and 3: leaky and clipped boundaries
    directed("t2", 2'd2, pack(16'hF000, 16'hFFFF, 16'h8000, 16'h0800),
             pack(16'hFE00, 16'hFFFF, 16'hF000, 16'h0800), 4'b0000);
    directed("t3", 2'd3, pack(16'h6000, 16'h6001, 16'h7FFF, 16'hC000),
             pack(16'h6000, 16'h6000, 16'h6000, 16'h0000), 4'b1000);

    // Test 4: backpressure fills both stages, then drains in order
    out_ready = 1'b0; acc = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; mode = 2'(i % 4);
      in_data  = pack(16'(100 * (acc + 1)), 16'hF000, 16'(acc), 16'h8000);
      @(negedge clk);
      if (i >= 2) chk("t4_in_ready", 64'(in_ready), 64'd0);
      if (in_valid && in_ready) acc++;
      tick();
    end
    chk("t4_accepted", 64'(acc), 64'd2);
    drain();

    // Test 5: alternating bypass/ReLU with no bubbles
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i < 6); mode = 2'(i % 2); in_data = {4{16'hF000}};
      @(negedge clk);
      if (i >= 2 && i <= 7) begin
        chk("t5_valid", 64'(out_valid), 64'd1);
        chk("t5_data", out_data, ((i - 2) % 2 == 0) ? {4{16'hF000}} : 64'd0);
      end
      tick();
    end
    in_valid = 1'b0;
    drain();

    // Test 6: reset with both stages full discards everything
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; mode = 2'd0; in_data = pack(16'h1234, 16'(i + 1), 16'h5555, 16'hAAAA);
      tick();
    end
    reset = 1'b1;
    @(negedge clk);
    chk("t6_ready_in_reset", 64'(in_ready), 64'd1);
    tick();
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_data", out_data, 64'd0);
    chk("t6_mask", 64'(out_zero_mask), 64'd0);
    chk("t6_ready", 64'(in_ready), 64'd1);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_no_stale", 64'(out_valid), 64'd0);
      tick();
    end

    // Randomized stream with random backpressure
    rand_phase(400);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
